multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32I datapath. It is the producer side of the control-signal interface that the datapath consumes.
- Inputs: the instruction register fields and the ALU zero flag.
- Outputs: every mux select, write enable and ALU control code, sequenced per instruction class.
- Supports lw, sw, R-type add/sub/and/or, I-type addi/andi/ori and beq. Opcode 0 halts the core.

Parameters:
- HALT_ON_ZERO, 1: when 1, opcode 7'b0000000 enters HALT. When 0, opcode 0 is treated as an unsupported opcode (NOP).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- opcode  in  7  inst[6:0] from IR
- funct3  in  3  inst[14:12]
- funct7b5  in  1  inst[30]
- zero  in  1  ALU zero flag (combinational)
- PCWrite  out  1  PC load enable
- IorD  out  1  1 = memory address from ALUOut, 0 = from PC
- memRead  out  1  memory read enable
- memWrite  out  1  memory write enable
- IRWrite  out  1  IR load enable
- MemtoReg  out  1  1 = register write data from MDR, 0 = from ALUOut
- regWrite  out  1  register file write enable
- ALUSrcA  out  1  1 = ALU A input from A register, 0 = from PC
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = constant 4, 10 = immediate
- PCSource  out  1  1 = PC next from ALUOut, 0 = from ALU result
- alu_control  out  4  0000 and, 0001 or, 0010 add, 0110 sub
- halted  out  1  high while in HALT
- state_dbg  out  4  current state encoding

Behaviour:
- Reset:
  - Async assert forces state to FETCH. Mid-instruction reset abandons the instruction.
  - While reset is high: all enables (PCWrite, memRead, memWrite, IRWrite, regWrite) are 0, all selects 0, alu_control = 0010, halted = 0.
- Output timing: all outputs are a Moore decode of state, except PCWrite in BRANCH, which is Mealy on zero. Any unlisted output is 0.
- FETCH:
  - memRead=1, IorD=0, IRWrite=1.
  - ALUSrcA=0, ALUSrcB=01, alu_control=add, so ALUOut latches PC+4.
  - Next state: DECODE.
- DECODE:
  - PCWrite=1, PCSource=1: PC <= PC+4 (the ALUOut value from FETCH).
  - ALUSrcA=0, ALUSrcB=10, add: ALUOut latches old PC + imm (branch target).
  - A/B latch rs1/rs2.
  - Next state by opcode:
    - 0000011 or 0100011 → MEM_ADDR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 with funct3=000 → BRANCH
    - 0000000 with HALT_ON_ZERO=1 → HALT
    - anything else → FETCH (NOP)
- MEM_ADDR:
  - ALUSrcA=1, ALUSrcB=10, add.
  - Next state: MEM_READ if opcode=0000011, else MEM_WRITE.
- MEM_READ: memRead=1, IorD=1; MDR latches. Next state: MEM_WB.
- MEM_WB: regWrite=1, MemtoReg=1. Next state: FETCH.
- MEM_WRITE: memWrite=1, IorD=1. Next state: FETCH.
- EXEC_R:
  - ALUSrcA=1, ALUSrcB=00.
  - alu_control from funct3/funct7b5: 000/0 add, 000/1 sub, 111 and, 110 or, other add.
  - Next state: ALU_WB.
- EXEC_I:
  - ALUSrcA=1, ALUSrcB=10.
  - alu_control: funct3 000 add, 111 and, 110 or, other add (funct7b5 ignored).
  - Next state: ALU_WB.
- ALU_WB: regWrite=1, MemtoReg=0. Next state: FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, sub.
  - PCSource=1; PCWrite = zero.
  - Next state: FETCH.
- HALT: all enables 0, halted=1. Sticky until reset.
- Cycles per instruction: lw 5; sw, R-type, I-type 4; beq 3; NOP 2.
- memRead and memWrite are never high in the same cycle. regWrite is only high in MEM_WB or ALU_WB.
- Illegal state encodings go to FETCH on the next clock.

Decomposition:
- Shared package:
  - state encodings (4-bit): FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, HALT=10
  - opcode constants
  - ALU control codes and ALUSrcB select codes
- One sub-module: alu_decoder. It is combinational and maps (alu_op class, funct3, funct7b5) to alu_control. The FSM drives the class: ADD, SUB, R-type or I-type.

Test Plan:
1. Reset high for 2 cycles, release → state_dbg=FETCH. Cycle 1 has memRead=IRWrite=1, ALUSrcB=01; all other enables 0.
2. Integrated program from PC 0:
   - addi x3,x0,20; lw x8,120(x3); add x10,x3,x8; sub x11,x10,x8, with mem[140]=82.
   - Required: x3=20, x8=82, x10=102, x11=20.
   - halted rises after 17 instruction cycles plus HALT entry: the opcode-0 fetch at PC 16.
3. sw x8,0(x3) with x3=20, x8=0x12345678 → memWrite exactly one cycle in state 5 with IorD=1; bytes 20..23 = 78 56 34 12.
4. beq at PC 8, imm=+8:
   - x1==x2 → PC=16 after 3 cycles.
   - x1!=x2 → PC=12.
5. Unsupported opcode 1101111 → DECODE then FETCH; no regWrite or memWrite; PC advances by 4.
6. Assert reset during MEM_READ of lw → state returns to FETCH immediately; regWrite never pulses; PC=0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU control codes, ALU B-source selects and the decoded control word.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_HALT      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_HALT   = 7'b0000000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // Operation class requested by the FSM; the decoder resolves it to a code.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_RTYPE = 2'd2,
        ALUOP_ITYPE = 2'd3
    } alu_op_t;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_source;
        logic       alu_en;
        alu_op_t    alu_op;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's operation class plus the
// instruction's funct fields to a 4-bit ALU control code.
module multicycle_control_alu_decoder
    import multicycle_control_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_control
);

    always_comb begin
        // NOTE: default assigned first so no path through the case infers a latch.
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct3)
                    3'b000:  alu_control = funct7b5 ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_ADD;
                endcase
            end
            ALUOP_ITYPE: begin
                // funct7b5 is immediate bits for I-type, never a sub selector.
                case (funct3)
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I datapath: sequences mux selects,
// write enables and ALU control per instruction class.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit HALT_ON_ZERO = 1'b1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       regWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       PCSource,
    output logic [3:0] alu_control,
    output logic       halted,
    output logic [3:0] state_dbg
);

    state_t     state;
    ctrl_t      ctrl;
    logic [3:0] alu_dec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state <= S_MEM_ADDR;
                        OP_RTYPE:          state <= S_EXEC_R;
                        OP_ITYPE:          state <= S_EXEC_I;
                        OP_BRANCH:         state <= (funct3 == 3'b000) ? S_BRANCH : S_FETCH;
                        OP_HALT:           state <= HALT_ON_ZERO ? S_HALT : S_FETCH;
                        default:           state <= S_FETCH;
                    endcase
                end
                S_MEM_ADDR:  state <= (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  state <= S_MEM_WB;
                S_MEM_WB:    state <= S_FETCH;
                S_MEM_WRITE: state <= S_FETCH;
                S_EXEC_R:    state <= S_ALU_WB;
                S_EXEC_I:    state <= S_ALU_WB;
                S_ALU_WB:    state <= S_FETCH;
                S_BRANCH:    state <= S_FETCH;
                S_HALT:      state <= S_HALT;
                default:     state <= S_FETCH;
            endcase
        end
    end

    // Moore decode of state; reset forces every output to its idle value
    // combinationally so nothing is enabled while reset is held.
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALUOP_ADD;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.ir_write  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_en    = 1'b1;
                end
                S_DECODE: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_en    = 1'b1;
                end
                S_MEM_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_en    = 1'b1;
                end
                S_MEM_READ: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                S_MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                end
                S_EXEC_R: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_en    = 1'b1;
                    ctrl.alu_op    = ALUOP_RTYPE;
                end
                S_EXEC_I: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_en    = 1'b1;
                    ctrl.alu_op    = ALUOP_ITYPE;
                end
                S_ALU_WB: ctrl.reg_write = 1'b1;
                S_BRANCH: begin
                    // PC load follows the live compare result in this state only.
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_en    = 1'b1;
                    ctrl.alu_op    = ALUOP_SUB;
                    ctrl.pc_source = 1'b1;
                    ctrl.pc_write  = zero;
                end
                S_HALT:  ctrl.halted = 1'b1;
                default: ;
            endcase
        end
    end

    multicycle_control_alu_decoder u_alu_decoder (
        .alu_op      (ctrl.alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_control (alu_dec)
    );

    assign PCWrite     = ctrl.pc_write;
    assign IorD        = ctrl.iord;
    assign memRead     = ctrl.mem_read;
    assign memWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign regWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign alu_control = reset ? ALU_ADD : (ctrl.alu_en ? alu_dec : 4'b0000);
    assign halted      = ctrl.halted;
    assign state_dbg   = state;

endmodule
